// File: rtl/mem_wb_skid_reg.sv
// MEM/WB boundary register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional load extension is enabled by defining MEM_WB_LOAD_EXT_EN.
module mem_wb_skid_reg #(
  parameter int NB_DATA = 32,
  parameter int NB_REG  = 5,
  parameter int NB_PC   = 32,
  parameter int NB_CNT  = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_flush,
  input  logic               i_MEM_valid,
  output logic               o_MEM_ready,
  input  logic               i_MEM_reg_write,
  input  logic               i_MEM_mem_to_reg,
  input  logic               i_MEM_r31_ctrl,
  input  logic [NB_DATA-1:0] i_MEM_mem_data,
  input  logic [NB_DATA-1:0] i_MEM_alu_result,
  input  logic [NB_REG-1:0]  i_MEM_selected_reg,
  input  logic [NB_PC-1:0]   i_MEM_pc,
  input  logic [1:0]         i_MEM_load_size,
  input  logic               i_MEM_load_unsigned,
  input  logic               i_WB_ready,
  output logic               o_WB_valid,
  output logic               o_WB_reg_write,
  output logic [NB_REG-1:0]  o_WB_wb_reg,
  output logic [NB_DATA-1:0] o_WB_wb_data,
  output logic [NB_CNT-1:0]  o_WB_retired
);

  typedef struct packed {
    logic               reg_write;
    logic               mem_to_reg;
    logic               r31_ctrl;
    logic [NB_DATA-1:0] mem_data;
    logic [NB_DATA-1:0] alu_result;
    logic [NB_REG-1:0]  selected_reg;
    logic [NB_PC-1:0]   pc;
    logic [1:0]         load_size;
    logic               load_unsigned;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t              state_reg;
  entry_t              main_reg;
  entry_t              skid_reg;
  entry_t              in_entry;
  logic                valid_reg;
  logic                ready_reg;
  logic [NB_CNT-1:0]   retired_reg;
  logic                in_fire;
  logic                out_fire;
  logic [NB_DATA-1:0]  mem_ext;
  logic [NB_DATA-1:0]  pc_ext;

  always_comb begin
    in_entry               = '0;
    in_entry.reg_write     = i_MEM_reg_write;
    in_entry.mem_to_reg    = i_MEM_mem_to_reg;
    in_entry.r31_ctrl      = i_MEM_r31_ctrl;
    in_entry.mem_data      = i_MEM_mem_data;
    in_entry.alu_result    = i_MEM_alu_result;
    in_entry.selected_reg  = i_MEM_selected_reg;
    in_entry.pc            = i_MEM_pc;
    in_entry.load_size     = i_MEM_load_size;
    in_entry.load_unsigned = i_MEM_load_unsigned;
  end

  // ready is a plain register so i_WB_ready never reaches o_MEM_ready combinationally
  assign in_fire  = i_MEM_valid & ready_reg;
  assign out_fire = valid_reg & i_WB_ready;

  always_ff @(negedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_reg   <= EMPTY;
      main_reg    <= '0;
      skid_reg    <= '0;
      valid_reg   <= 1'b0;
      ready_reg   <= 1'b1;
      retired_reg <= '0;
    end else begin
      if (out_fire) begin
        retired_reg <= retired_reg + NB_CNT'(1);
      end
      if (i_flush) begin
        state_reg <= EMPTY;
        valid_reg <= 1'b0;
        ready_reg <= 1'b1;
      end else begin
        case (state_reg)
          EMPTY: begin
            if (in_fire) begin
              main_reg  <= in_entry;
              valid_reg <= 1'b1;
              state_reg <= FULL;
            end
          end
          FULL: begin
            if (in_fire && out_fire) begin
              main_reg <= in_entry;
            end else if (in_fire) begin
              skid_reg  <= in_entry;
              ready_reg <= 1'b0;
              state_reg <= SKID;
            end else if (out_fire) begin
              valid_reg <= 1'b0;
              state_reg <= EMPTY;
            end
          end
          SKID: begin
            if (out_fire) begin
              main_reg  <= skid_reg;
              ready_reg <= 1'b1;
              state_reg <= FULL;
            end
          end
          default: begin
            state_reg <= EMPTY;
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef MEM_WB_LOAD_EXT_EN
  always_comb begin
    mem_ext = main_reg.mem_data;
    case (main_reg.load_size)
      2'b00: begin
        mem_ext      = {NB_DATA{~main_reg.load_unsigned & main_reg.mem_data[7]}};
        mem_ext[7:0] = main_reg.mem_data[7:0];
      end
      2'b01: begin
        mem_ext       = {NB_DATA{~main_reg.load_unsigned & main_reg.mem_data[15]}};
        mem_ext[15:0] = main_reg.mem_data[15:0];
      end
      default: mem_ext = main_reg.mem_data;
    endcase
  end
`else
  logic unused_load_fields;
  assign unused_load_fields = ^{main_reg.load_size, main_reg.load_unsigned};
  assign mem_ext = main_reg.mem_data;
`endif

  always_comb begin
    pc_ext              = '0;
    pc_ext[NB_PC-1:0]   = main_reg.pc;
  end

  assign o_MEM_ready    = ready_reg;
  assign o_WB_valid     = valid_reg;
  assign o_WB_reg_write = valid_reg & main_reg.reg_write;
  assign o_WB_wb_reg    = main_reg.r31_ctrl ? NB_REG'(31) : main_reg.selected_reg;
  assign o_WB_wb_data   = main_reg.r31_ctrl   ? pc_ext :
                          main_reg.mem_to_reg ? mem_ext :
                                                main_reg.alu_result;
  assign o_WB_retired   = retired_reg;

endmodule

// File: doc/mem_wb_skid_reg.md
# mem_wb_skid_reg

Parametrised MEM/WB pipeline boundary register with a valid/ready handshake, a 2-entry skid buffer, synchronous flush, write-back source selection and a retired-instruction counter. It sits between the MEM stage and the register-file write port. Unlike a plain latch it can absorb one cycle of WB-side back-pressure without dropping data, and it never lets a bubble write the register file.

## Interface
Parameters:
- NB_DATA, 32, width of memory data, ALU result and write-back data
- NB_REG, 5, register-index width
- NB_PC, 32, width of the PC/link value; must be ≤ NB_DATA
- NB_CNT, 32, width of retired-instruction counter

Ports:
- i_clock  in  1  clock; all state updates on the falling edge
- i_reset  in  1  asynchronous, active-high reset
- i_flush  in  1  synchronous flush; invalidates all held entries
- i_MEM_valid  in  1  MEM presents a valid instruction
- o_MEM_ready  out  1  block can accept this cycle
- i_MEM_reg_write  in  1  instruction writes the register file
- i_MEM_mem_to_reg  in  1  select memory data (1) or ALU result (0)
- i_MEM_r31_ctrl  in  1  link write: data = PC, dest = r31
- i_MEM_mem_data  in  NB_DATA  load data, already right-aligned
- i_MEM_alu_result  in  NB_DATA  ALU result
- i_MEM_selected_reg  in  NB_REG  destination register
- i_MEM_pc  in  NB_PC  link value (return address)
- i_MEM_load_size  in  2  00 byte, 01 half, 1x word
- i_MEM_load_unsigned  in  1  zero-extend (1) or sign-extend (0)
- i_WB_ready  in  1  WB consumes the output this cycle
- o_WB_valid  out  1  output entry is valid
- o_WB_reg_write  out  1  reg_write AND o_WB_valid
- o_WB_wb_reg  out  NB_REG  31 if r31_ctrl, else selected_reg
- o_WB_wb_data  out  NB_DATA  selected write-back value
- o_WB_retired  out  NB_CNT  count of completed output transfers

## Operation
- Two entries: MAIN, which drives the outputs, and SKID. Input fire = i_MEM_valid & o_MEM_ready. Output fire = o_WB_valid & i_WB_ready.
- o_MEM_ready = !SKID.valid. This is a direct register output with no combinational path from i_WB_ready.
- States:
  - EMPTY (MAIN and SKID invalid)
  - FULL (MAIN valid, SKID invalid)
  - SKID (both valid)
- Transitions:
  - EMPTY: in fire → FULL, MAIN loads the input.
  - FULL: in and out fire → FULL, MAIN loads the input. In fire only → SKID, SKID loads the input. Out fire only → EMPTY.
  - SKID: out fire → FULL, MAIN ← SKID. Otherwise hold.
- Flush has priority over everything. On the next edge both entries are invalid and the state is EMPTY. An input firing in the flush cycle is discarded. An output fire in the flush cycle still counts as retired.
- Write-back selection (combinational from MAIN): r31_ctrl → PC zero-extended to NB_DATA. Else mem_to_reg → processed mem_data. Else alu_result.
- o_WB_retired increments by 1 on each output fire and wraps modulo 2^NB_CNT. It is not cleared by flush.
- Payload registers have no enable requirement when invalid. Outputs other than o_WB_valid, o_WB_reg_write and o_MEM_ready are don't-care while invalid.

## Timing
- Reset values:
  - o_WB_valid = 0, o_WB_reg_write = 0
  - o_MEM_ready = 1, o_WB_retired = 0
  - o_WB_wb_reg = 0, o_WB_wb_data = 0
  - State = EMPTY
- Latency: an input accepted at falling edge n is visible at the output after edge n.
- Throughput: one transfer per cycle when i_WB_ready is held high.
- i_WB_ready low with a valid output: the next accepted input goes to SKID, and o_MEM_ready drops after that edge.
- Reset asserted mid-operation clears both entries immediately, independent of the clock.

## Configuration
- Macro MEM_WB_LOAD_EXT_EN.
- When defined: mem_data is extended before selection. Byte takes bits [7:0] and half takes bits [15:0], each sign- or zero-extended per load_unsigned. Word passes unchanged. Extension is applied to the latched size and unsigned fields.
- When undefined: i_MEM_load_size and i_MEM_load_unsigned remain as ports but are ignored, and mem_data passes unchanged.

## Test plan
- Reset, then three back-to-back fires with i_WB_ready=1, alu 0x11/0x22/0x33 → outputs appear one per cycle in order; o_WB_retired=3; o_MEM_ready stays 1.
- Fire A (0xAAAA) with WB stalled, then fire B (0xBBBB) → o_MEM_ready=0 and output holds A. Release ready → A, then B. No loss or duplication.
- State SKID, assert i_flush together with i_MEM_valid → next cycle o_WB_valid=0, o_WB_reg_write=0, o_MEM_ready=1, and the input is not delivered.
- r31_ctrl=1, pc=0x0000_0040, selected_reg=7 → o_WB_wb_reg=31, o_WB_wb_data=0x40.
- With MEM_WB_LOAD_EXT_EN: mem_to_reg=1, mem_data=0x0000_0080, byte signed → 0xFFFF_FF80; byte unsigned → 0x80; half signed with 0x8001 → 0xFFFF_8001. Without the macro, all three give the raw input.
- Assert i_reset asynchronously between clock edges while in SKID → outputs take their reset values immediately; o_WB_retired=0.
